// File: rtl/keypad_scanner.sv
// Drives one active-high column at a time and gates the row debouncer. Accepted row pulses latch into a 16-bit request vector.
// All outputs are registered, one cycle after the accepting edge. There is no backpressure: the scan free-runs while scan_en is high.
module keypad_scanner #(
    parameter int SETTLE = 2,
    parameter int DWELL  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_en,
    input  logic [3:0]  buttonMux,
    input  logic        clr,
    input  logic [3:0]  clr_idx,
    output logic [3:0]  col,
    output logic        en,
    output logic [15:0] req,
    output logic        req_valid,
    output logic [3:0]  key_code
);

    localparam int CMAX = (SETTLE > DWELL) ? SETTLE : DWELL;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL - 1);
    localparam logic [CW-1:0] ACC_MIN     = CW'(2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [1:0]    r_col_idx;
    logic [1:0]    w_col_idx_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [3:0]    r_col;
    logic [3:0]    w_col_nxt;
    logic          r_en;
    logic          w_en_nxt;
    logic [15:0]   r_req;
    logic [15:0]   w_req_nxt;
    logic          r_req_valid;
    logic [3:0]    r_key_code;

    logic          w_accept;
    logic [15:0]   w_set;
    logic [15:0]   w_new;
    logic [15:0]   w_clr;
    logic [3:0]    w_low;

    always_comb begin
        w_state_nxt   = r_state;
        w_col_idx_nxt = r_col_idx;
        w_cnt_nxt     = r_cnt;
        if (!scan_en) begin
            w_state_nxt   = S_IDLE;
            w_col_idx_nxt = 2'd0;
            w_cnt_nxt     = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SETTLE;
                    w_cnt_nxt   = '0;
                end
                S_SETTLE: begin
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = S_SAMPLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == DWELL_LAST) begin
                        w_state_nxt   = S_SETTLE;
                        w_cnt_nxt     = '0;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt   = S_IDLE;
                    w_col_idx_nxt = 2'd0;
                    w_cnt_nxt     = '0;
                end
            endcase
        end
        // Column and enable come from the next state so both move on the same edge.
        w_col_nxt = (w_state_nxt == S_IDLE) ? 4'b0000 : (4'b0001 << w_col_idx_nxt);
        w_en_nxt  = (w_state_nxt == S_SAMPLE);
    end

    // The first two SAMPLE cycles carry stale data from the debouncer pipeline refill.
    assign w_accept  = (r_state == S_SAMPLE) && (r_cnt >= ACC_MIN);
    assign w_set     = w_accept ? ({12'h000, buttonMux} << {r_col_idx, 2'b00}) : 16'h0000;
    assign w_new     = w_set & ~r_req;
    assign w_clr     = clr ? (16'h0001 << clr_idx) : 16'h0000;
    assign w_req_nxt = (r_req & ~w_clr) | w_set;

    always_comb begin
        w_low = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (w_new[i]) begin
                w_low = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col_idx   <= 2'd0;
            r_cnt       <= '0;
            r_col       <= 4'b0000;
            r_en        <= 1'b0;
            r_req       <= 16'h0000;
            r_req_valid <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_col_idx   <= w_col_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_col       <= w_col_nxt;
            r_en        <= w_en_nxt;
            r_req       <= w_req_nxt;
            r_req_valid <= |w_new;
            if (|w_new) begin
                r_key_code <= w_low;
            end
        end
    end

    assign col       = r_col;
    assign en        = r_en;
    assign req       = r_req;
    assign req_valid = r_req_valid;
    assign key_code  = r_key_code;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SETTLE=2 and DWELL=8.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [3:0]  buttonMux;
    logic        clr;
    logic [3:0]  clr_idx;
    logic [3:0]  col;
    logic        en;
    logic [15:0] req;
    logic        req_valid;
    logic [3:0]  key_code;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;

    typedef struct {
        int          due;
        logic [3:0]  kc;
        logic [15:0] rq;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_req;
    logic [3:0]  m_kc;
    int          k;

    keypad_scanner #(.SETTLE(2), .DWELL(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .buttonMux (buttonMux),
        .clr       (clr),
        .clr_idx   (clr_idx),
        .col       (col),
        .en        (en),
        .req       (req),
        .req_valid (req_valid),
        .key_code  (key_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_cnt);
        end
    endtask

    function automatic logic [3:0] lowest(input logic [15:0] v);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    // Pops an expectation whenever one falls due; a req_valid with nothing due is an error.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc_cnt) begin
                e = sb.pop_front();
                check("req_valid", 32'(req_valid), 32'd1);
                check("key_code_new", 32'(key_code), 32'(e.kc));
                check("req_on_valid", 32'(req), 32'(e.rq));
            end else if (req_valid) begin
                check("spurious_req_valid", 32'(req_valid), 32'd0);
            end
        end
    end

    // Called at a falling edge: checks this cycle's outputs, drives inputs, advances one cycle.
    task automatic step(input logic [3:0] bm, input logic c, input logic [3:0] ci);
        logic [15:0] set_m;
        logic [15:0] new_m;
        logic [15:0] clr_m;
        logic [3:0]  want_col;
        logic        want_en;
        logic        acc;
        want_col = (k < 0) ? 4'b0000 : 4'(1 << ((k / 10) % 4));
        want_en  = (k >= 0) && ((k % 10) >= 2);
        check("col", 32'(col), 32'(want_col));
        check("en", 32'(en), 32'(want_en));
        check("req", 32'(req), 32'(m_req));
        check("key_code_hold", 32'(key_code), 32'(m_kc));
        buttonMux = bm;
        clr       = c;
        clr_idx   = ci;
        acc   = (k >= 0) && ((k % 10) >= 4);
        set_m = acc ? ({12'h000, bm} << (4 * ((k / 10) % 4))) : 16'h0000;
        new_m = set_m & ~m_req;
        clr_m = c ? (16'h0001 << ci) : 16'h0000;
        m_req = (m_req & ~clr_m) | set_m;
        if (new_m != 16'h0000) begin
            m_kc = lowest(new_m);
            sb.push_back('{cyc_cnt + 1, m_kc, m_req});
        end
        @(negedge clk);
        k = scan_en ? k + 1 : -1;
        buttonMux = 4'b0000;
        clr       = 1'b0;
    endtask

    task automatic run_to(input int t);
        for (int i = 0; i < 45 && (k % 40) != t; i++) step(4'b0000, 1'b0, 4'd0);
    endtask

    initial begin
        rst       = 1'b1;
        scan_en   = 1'b0;
        buttonMux = 4'b0000;
        clr       = 1'b0;
        clr_idx   = 4'd0;
        m_req     = 16'h0000;
        m_kc      = 4'd0;
        k         = -1;
        repeat (2) @(negedge clk);
        check("rst_col", 32'(col), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_req", 32'(req), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);
        check("rst_key_code", 32'(key_code), 32'd0);
        rst = 1'b0;
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);

        // Column 1, SAMPLE counter 3: row 2 -> bit 6.
        scan_en = 1'b1;
        step(4'b0000, 1'b0, 4'd0);
        run_to(15);
        step(4'b0100, 1'b0, 4'd0);

        // All rows during SETTLE and SAMPLE counters 0 and 1 of column 2 are ignored.
        run_to(20);
        repeat (4) step(4'b1111, 1'b0, 4'd0);

        // Column 3, rows 1 and 3 together, then the same pulse on the next scan.
        run_to(35);
        step(4'b1010, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        run_to(35);
        step(4'b1010, 1'b0, 4'd0);

        // Clear bit 6, then set and clear it in one cycle, then clear an empty bit.
        step(4'b0000, 1'b1, 4'd6);
        run_to(15);
        step(4'b0100, 1'b1, 4'd6);
        step(4'b0000, 1'b1, 4'd0);

        // Drop scanning in column 2, clear while idle, then restart.
        run_to(26);
        scan_en = 1'b0;
        step(4'b0000, 1'b0, 4'd0);
        step(4'b1111, 1'b0, 4'd0);
        step(4'b0000, 1'b1, 4'd13);
        step(4'b0000, 1'b0, 4'd0);
        scan_en = 1'b1;
        step(4'b0000, 1'b0, 4'd0);
        run_to(6);
        step(4'b0001, 1'b0, 4'd0);

        // Asynchronous reset during column 1 SAMPLE.
        run_to(17);
        #2;
        rst = 1'b1;
        #1;
        check("arst_col", 32'(col), 32'd0);
        check("arst_en", 32'(en), 32'd0);
        check("arst_req", 32'(req), 32'd0);
        check("arst_req_valid", 32'(req_valid), 32'd0);
        check("arst_key_code", 32'(key_code), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        m_req = 16'h0000;
        m_kc  = 4'd0;
        k     = -1;
        sb.delete();
        repeat (14) step(4'b0000, 1'b0, 4'd0);
        step(4'b0100, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        step(4'b0000, 1'b0, 4'd0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
